// File: rtl/serial_pkg.sv
// Shared types and register-map constants for the serial transmit port.
// Optional parity support is enabled by defining SERIAL_PARITY_EN.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic [3:0] SERIAL_REGION_ID = 4'hF;

   localparam logic [3:0] REG_DATA   = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h4;
   localparam logic [3:0] REG_DIV    = 4'h8;

   // STATUS bit positions; the FIFO count occupies an 8-bit field from ST_COUNT_LSB.
   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_PARITY    = 4;
   localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered occupancy count; a push is accepted when
// full as long as a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr_q, rdPtr_q;
   logic [AW:0]      count_q;
   logic             pushOk, popOk;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem[rdPtr_q];

   assign popOk  = pop_i && !empty_o;
   assign pushOk = push_i && (!full_o || popOk);

   always_ff @(posedge clk_i) begin
      if (pushOk) begin
         mem[wrPtr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
         if (popOk)  rdPtr_q <= rdPtr_q + 1'b1;
         unique case ({pushOk, popOk})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/serial_tx_port.sv
// Memory-mapped UART transmitter: bus writes fill a TX FIFO drained by an 8N1
// serialiser. Defining SERIAL_PARITY_EN adds a selectable even/odd parity bit.
module serial_tx_port
   import serial_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        sel_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] din_i,
   output logic [31:0] dout_o,
   output logic        tx_o,
   output logic        irq_empty_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t   state_q;
   logic        tx_q;
   logic [15:0] baud_q, divEff_q;
   logic [2:0]  bitIdx_q;
   logic [7:0]  shift_q;
   logic [15:0] div_q, div_d;
   logic        overflow_q, overflow_d;
   logic        parityOdd_q, parityOdd_d;
   logic        parity_q;

   logic [3:0]    regOff;
   logic          busWr, fifoPush, fifoPop, lastTick;
   logic          fifoFull, fifoEmpty;
   logic [7:0]    fifoRdata;
   logic [CW-1:0] fifoCount;
   logic [15:0]   divEff;
   logic [31:0]   statusWord;
   logic          unusedBits;

   assign regOff     = {addr_i[3:2], 2'b00};
   assign busWr      = sel_i && we_i;
   assign fifoPush   = busWr && (regOff == REG_DATA);
   assign lastTick   = (baud_q == '0);
   assign fifoPop    = !fifoEmpty && ((state_q == IDLE) || ((state_q == STOP) && lastTick));
   assign divEff     = (div_q == '0) ? 16'd1 : div_q;
   assign unusedBits = ^{din_i[31:16], addr_i[1:0]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifoPush),
      .pop_i   (fifoPop),
      .wdata_i (din_i[7:0]),
      .rdata_o (fifoRdata),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (fifoCount)
   );

   // A drop only counts as overflow when no pop frees a slot in the same cycle.
   always_comb begin
      div_d       = div_q;
      overflow_d  = overflow_q;
      parityOdd_d = parityOdd_q;
      if (fifoPush && fifoFull && !fifoPop) overflow_d = 1'b1;
      if (busWr && (regOff == REG_STATUS)) begin
         if (din_i[ST_OVERFLOW]) overflow_d = 1'b0;
`ifdef SERIAL_PARITY_EN
         parityOdd_d = din_i[ST_PARITY];
`endif
      end
      if (busWr && (regOff == REG_DIV)) div_d = din_i[15:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q       <= DIV_DEFAULT;
         overflow_q  <= 1'b0;
         parityOdd_q <= 1'b0;
      end else begin
         div_q       <= div_d;
         overflow_q  <= overflow_d;
         parityOdd_q <= parityOdd_d;
      end
   end

   // Serialiser: a pop (IDLE or last STOP tick) latches byte and divisor for the whole frame.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         tx_q     <= 1'b1;
         baud_q   <= '0;
         divEff_q <= 16'd1;
         bitIdx_q <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
      end else if (fifoPop) begin
         state_q  <= START;
         tx_q     <= 1'b0;
         shift_q  <= fifoRdata;
         divEff_q <= divEff;
         baud_q   <= divEff - 16'd1;
         parity_q <= (^fifoRdata) ^ parityOdd_q;
      end else begin
         unique case (state_q)
            IDLE: tx_q <= 1'b1;
            START: begin
               if (lastTick) begin
                  state_q  <= DATA;
                  bitIdx_q <= '0;
                  baud_q   <= divEff_q - 16'd1;
                  tx_q     <= shift_q[0];
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end
            DATA: begin
               if (lastTick) begin
                  baud_q <= divEff_q - 16'd1;
                  if (bitIdx_q == 3'd7) begin
`ifdef SERIAL_PARITY_EN
                     state_q <= PARITY;
                     tx_q    <= parity_q;
`else
                     state_q <= STOP;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     bitIdx_q <= bitIdx_q + 3'd1;
                     shift_q  <= {1'b0, shift_q[7:1]};
                     tx_q     <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end
`ifdef SERIAL_PARITY_EN
            PARITY: begin
               if (lastTick) begin
                  state_q <= STOP;
                  baud_q  <= divEff_q - 16'd1;
                  tx_q    <= 1'b1;
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end
`endif
            STOP: begin
               if (lastTick) begin
                  state_q <= IDLE;
                  tx_q    <= 1'b1;
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      statusWord                       = '0;
      statusWord[ST_FULL]              = fifoFull;
      statusWord[ST_EMPTY]             = fifoEmpty;
      statusWord[ST_BUSY]              = (state_q != IDLE);
      statusWord[ST_OVERFLOW]          = overflow_q;
      statusWord[ST_COUNT_LSB +: 8]    = 8'(fifoCount);
`ifdef SERIAL_PARITY_EN
      statusWord[ST_PARITY]            = parityOdd_q;
`endif
      dout_o = '0;
      if (sel_i) begin
         unique case (regOff)
            REG_STATUS: dout_o = statusWord;
            REG_DIV:    dout_o = {16'h0000, div_q};
            default:    dout_o = '0;
         endcase
      end
   end

   assign tx_o        = tx_q;
   assign irq_empty_o = fifoEmpty && (state_q == IDLE);

endmodule

// File: tb/tb_serial_tx_port.sv
// Self-checking bench for serial_tx_port: register-map vector table, directed
// corner-case sequences and random traffic against a queue-based line model.
module tb_serial_tx_port;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst, sel, we;
   logic [3:0]  addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        tx, irq;

   int total = 0;
   int bad   = 0;

   // Reference model: pending bytes, and the tx level expected on each future cycle.
   bit [7:0]    mq[$];
   bit          txq[$];
   logic [15:0] mdiv;
   bit          movf, modd;

   serial_tx_port #(.FIFO_DEPTH(DEPTH), .DIV_DEFAULT(16'd434)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .sel_i       (sel),
      .we_i        (we),
      .addr_i      (addr),
      .din_i       (din),
      .dout_o      (dout),
      .tx_o        (tx),
      .irq_empty_o (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          sel;
      bit          we;
      logic [3:0]  addr;
      logic [31:0] din;
      bit          chk;
      logic [31:0] exp;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] statusModel();
      logic [31:0] s;
      s        = '0;
      s[0]     = (mq.size() == DEPTH);
      s[1]     = (mq.size() == 0);
      s[2]     = (txq.size() != 0);
      s[3]     = movf;
`ifdef SERIAL_PARITY_EN
      s[4]     = modd;
`endif
      s[15:8]  = 8'(mq.size());
      return s;
   endfunction

   task automatic modelReset();
      mq.delete();
      txq.delete();
      mdiv = 16'd434;
      movf = 1'b0;
      modd = 1'b0;
   endtask

   task automatic appendFrame(input bit [7:0] b);
      int unsigned de;
      bit lv[$];
      de = (mdiv == 0) ? 1 : int'(mdiv);
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(b[i]);
`ifdef SERIAL_PARITY_EN
      lv.push_back((^b) ^ modd);
`endif
      lv.push_back(1'b1);
      foreach (lv[k]) repeat (de) txq.push_back(lv[k]);
   endtask

   // One clock with the currently driven inputs; the model follows the same edge.
   task automatic applyStimulus();
      bit       wr, doPop, doPush, ovfSet;
      bit [3:0] off;
      bit [7:0] b;
      if (rst) begin
         @(posedge clk);
         #1;
         modelReset();
      end else begin
         wr     = sel && we;
         off    = addr & 4'hC;
         doPop  = (mq.size() > 0) && (txq.size() <= 1);
         doPush = wr && (off == 4'h0) && ((mq.size() < DEPTH) || doPop);
         ovfSet = wr && (off == 4'h0) && (mq.size() == DEPTH) && !doPop;
         @(posedge clk);
         #1;
         if (txq.size() > 0) void'(txq.pop_front());
         if (doPop) begin
            b = mq.pop_front();
            appendFrame(b);
         end
         if (doPush) mq.push_back(din[7:0]);
         if (ovfSet) movf = 1'b1;
         if (wr && off == 4'h4) begin
            if (din[3]) movf = 1'b0;
`ifdef SERIAL_PARITY_EN
            modd = din[4];
`endif
         end
         if (wr && off == 4'h8) mdiv = din[15:0];
      end
      checkOutput("tx", 32'(tx), 32'((txq.size() != 0) ? txq[0] : 1'b1));
      checkOutput("irq_empty", 32'(irq), 32'((mq.size() == 0) && (txq.size() == 0)));
   endtask

   task automatic idle(input int n);
      sel = 0; we = 0; addr = 0; din = 0;
      repeat (n) applyStimulus();
   endtask

   task automatic writeReg(input logic [3:0] a, input logic [31:0] d);
      sel = 1; we = 1; addr = a; din = d;
      applyStimulus();
      sel = 0; we = 0;
   endtask

   task automatic readCheck(input string name, input logic [3:0] a);
      logic [31:0] exp;
      sel = 1; we = 0; addr = a; din = 0;
      #1;
      case (a & 4'hC)
         4'h4:    exp = statusModel();
         4'h8:    exp = {16'h0, mdiv};
         default: exp = '0;
      endcase
      checkOutput(name, dout, exp);
   endtask

   task automatic waitIdle(input int limit);
      int n = 0;
      idle(0);
      while ((mq.size() != 0 || txq.size() != 0) && n < limit) begin
         applyStimulus();
         n++;
      end
      checkOutput("waitIdleTimeout", 32'(n < limit), 32'd1);
   endtask

   initial begin
      vec_t vecs[$];
      int   r;

      vecs.push_back('{"rstDiv",      1, 0, 4'h8, 32'h0,        1, 32'h0000_01B2});
      vecs.push_back('{"rstStatus",   1, 0, 4'h4, 32'h0,        1, 32'h0000_0002});
      vecs.push_back('{"readData",    1, 0, 4'h0, 32'h0,        1, 32'h0});
      vecs.push_back('{"readHole",    1, 0, 4'hC, 32'h0,        1, 32'h0});
      vecs.push_back('{"noSelRead",   0, 0, 4'h8, 32'h0,        1, 32'h0});
      vecs.push_back('{"wrDiv",       1, 1, 4'h8, 32'hABCD1234, 0, 32'h0});
      vecs.push_back('{"divReadBack", 1, 0, 4'h8, 32'h0,        1, 32'h0000_1234});
      vecs.push_back('{"divLowAddr",  1, 0, 4'hB, 32'h0,        1, 32'h0000_1234});
      vecs.push_back('{"wrHole",      1, 1, 4'hC, 32'hFFFF,     0, 32'h0});
      vecs.push_back('{"holeStays0",  1, 0, 4'hC, 32'h0,        1, 32'h0});
      vecs.push_back('{"wrNoSel",     0, 1, 4'h8, 32'h7,        0, 32'h0});
      vecs.push_back('{"divKept",     1, 0, 4'h8, 32'h0,        1, 32'h0000_1234});
      vecs.push_back('{"wrStatusAll", 1, 1, 4'h4, 32'hFFFFFFFF, 0, 32'h0});
`ifdef SERIAL_PARITY_EN
      vecs.push_back('{"statusRO",    1, 0, 4'h4, 32'h0,        1, 32'h0000_0012});
`else
      vecs.push_back('{"statusRO",    1, 0, 4'h4, 32'h0,        1, 32'h0000_0002});
`endif
      vecs.push_back('{"wrStatus0",   1, 1, 4'h4, 32'h0,        0, 32'h0});
      vecs.push_back('{"statusClr",   1, 0, 4'h4, 32'h0,        1, 32'h0000_0002});

      modelReset();
      rst = 1; sel = 0; we = 0; addr = 0; din = 0;
      repeat (2) applyStimulus();
      rst = 0;

      foreach (vecs[i]) begin
         sel = vecs[i].sel; we = vecs[i].we; addr = vecs[i].addr; din = vecs[i].din;
         #1;
         if (vecs[i].chk) checkOutput(vecs[i].name, dout, vecs[i].exp);
         applyStimulus();
      end
      idle(1);

      // 0x55 at DIV=4
      writeReg(4'h8, 32'd4);
      writeReg(4'h0, 32'h55);
      waitIdle(200);
      checkOutput("irqAfterStop", 32'(irq), 32'd1);

      // Overflow while the line is busy, then clear it
      writeReg(4'h8, 32'd2);
      writeReg(4'h0, 32'h11);
      for (int i = 0; i < 17; i++) writeReg(4'h0, 32'(8'h20 + i));
      readCheck("fullStatus", 4'h4);
      checkOutput("fullStatusConst", dout, 32'h0000_100D);
      writeReg(4'h4, 32'h8);
      readCheck("ovfCleared", 4'h4);
      checkOutput("ovfClearedConst", dout, 32'h0000_1005);
      idle(0);

      // Push only on the pop cycles while full: no overflow expected
      for (int i = 0; i < 60; i++) begin
         if (mq.size() == DEPTH && txq.size() == 1) writeReg(4'h0, 32'(8'h80 + i));
         else idle(1);
      end
      readCheck("fullPushPop", 4'h4);
      checkOutput("fullPushPopOvf", 32'(dout[3]), 32'd0);
      checkOutput("fullPushPopCount", 32'(dout[15:8]), 32'd16);
      waitIdle(5000);

      // Back-to-back frames at DIV=3
      writeReg(4'h8, 32'd3);
      writeReg(4'h0, 32'hA5);
      writeReg(4'h0, 32'h3C);
      waitIdle(200);

      // DIV=0 behaves as one clock per bit
      writeReg(4'h8, 32'd0);
      writeReg(4'h0, 32'hFF);
      waitIdle(50);

      // Divisor change mid-frame
      writeReg(4'h8, 32'd4);
      writeReg(4'h0, 32'h96);
      writeReg(4'h0, 32'h69);
      idle(17);
      writeReg(4'h8, 32'd8);
      waitIdle(400);

      // Reset during DATA bit 5
      writeReg(4'h8, 32'd4);
      writeReg(4'h0, 32'hC3);
      idle(26);
      rst = 1;
      applyStimulus();
      rst = 0;
      checkOutput("rstMidTx", 32'(tx), 32'd1);
      readCheck("rstMidStatus", 4'h4);
      checkOutput("rstMidStatusConst", dout, 32'h0000_0002);
      readCheck("rstMidDiv", 4'h8);
      checkOutput("rstMidDivConst", dout, 32'h0000_01B2);
      idle(1);

`ifdef SERIAL_PARITY_EN
      writeReg(4'h4, 32'h10);
      writeReg(4'h8, 32'd2);
      writeReg(4'h0, 32'h01);
      waitIdle(100);
      writeReg(4'h4, 32'h0);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 199));
         if (r < 2) begin
            sel = 0; we = 0; rst = 1;
            applyStimulus();
            rst = 0;
         end else if (r < 70) begin
            writeReg(4'h0, $urandom());
         end else if (r < 80) begin
            writeReg(4'h8, 32'($urandom_range(0, 4)) | ($urandom() & 32'hFFFF_0000));
         end else if (r < 88) begin
            writeReg(4'h4, $urandom());
         end else if (r < 110) begin
            readCheck("randRead", 4'($urandom_range(0, 15)));
            applyStimulus();
         end else begin
            idle(1);
         end
      end
      waitIdle(5000);
      readCheck("finalStatus", 4'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_tx_port.md
Name: serial_tx_port

Overview:
Memory-mapped UART transmitter that responds on the data bus at region id 0xF, the region whose select the address decoder drives as sel_serial. The CPU writes bytes into a TX FIFO. An 8N1 serialiser drains the FIFO at a programmable baud divisor. The status register is readable so software can poll for space and idle.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
DIV_DEFAULT, 16'd434, reset value of the baud divisor in clocks per bit (50 MHz / 115200).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sel  in  1  region select from the address decoder (addr[23:20]==4'hF)
we  in  1  bus write strobe; acts only when sel=1
addr  in  4  byte offset within the region (addr[3:0])
din  in  32  bus write data
dout  out  32  bus read data; combinational from registers; 0 when sel=0
tx  out  1  serial line; idles high
irq_empty  out  1  high while FIFO is empty and the serialiser is idle

Behaviour:
- Register map (word offsets; addr[1:0] ignored):
  - 0x0 DATA: write pushes din[7:0]; reads return 0.
  - 0x4 STATUS: read-only except bit3. Bit0 full, bit1 empty, bit2 busy (serialiser not IDLE), bit3 overflow (sticky; write 1 to clear), bits[15:8] FIFO count.
  - 0x8 DIV: divisor in bits[15:0]; read-back is the stored value.
  - Other offsets: reads return 0; writes are ignored.
- Reset: tx=1, FIFO empty, count=0, overflow=0, DIV=DIV_DEFAULT, state=IDLE, irq_empty=1. Reset mid-frame aborts the frame; tx is high on the cycle after rst is sampled.
- Push rules:
  - A DATA write while not full is stored at the next edge.
  - A DATA write while full is dropped and sets overflow.
  - If a push and a pop fall in the same cycle while full, both succeed and overflow is not set.
- Serialiser FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when FIFO is non-empty, pop the head, latch the byte and latch div_eff = (DIV==0 ? 1 : DIV); go to START. The start bit drives on the cycle after the pop.
  - START: tx=0 for div_eff clocks.
  - DATA: bits 0..7 LSB first, each for div_eff clocks. The bit index counts 0..7, then moves to STOP.
  - STOP: tx=1 for div_eff clocks. Then IDLE, or straight to the next frame: a pop in the STOP last cycle lets START follow with no gap.
- Baud counter: loads div_eff-1 on entering each bit and decrements. The bit ends when the counter is 0.
- A DIV write mid-frame does not affect the current frame; it takes effect at the next latch.
- A push to an empty FIFO while in IDLE: that byte pops on the following cycle; there is no same-cycle bypass.
- The count is always in 0..FIFO_DEPTH. The pointers wrap modulo FIFO_DEPTH.

Optional Feature:
SERIAL_PARITY_EN
- Defined: STATUS bit4 is a read/write parity-odd select (reset 0 = even). The FSM inserts a PARITY state between DATA and STOP, transmitting the XOR of the 8 data bits, inverted when odd is selected, for div_eff clocks.
- Undefined: no PARITY state; STATUS bit4 reads 0 and ignores writes; frames are 8N1.

Decomposition:
- serial_pkg:
  - State enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Offsets REG_DATA=4'h0, REG_STATUS=4'h4, REG_DIV=4'h8.
  - STATUS bit-position constants.
  - SERIAL_REGION_ID=4'hF.
- Sub-module sync_fifo (width 8, depth FIFO_DEPTH):
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Same-cycle push+pop allowed when full or non-empty.

Test Plan:
1. Reset, then DIV=4; write DATA 0x55 -> tx low 4 clk, then 1,0,1,0,1,0,1,0 at 4 clk each, then high 4 clk; irq_empty returns to 1 after the stop bit.
2. With DIV=2 and the line held busy, push 17 bytes -> STATUS reads full=1, count=16, overflow=1; write STATUS 0x8 -> overflow=0.
3. Push 0xA5 and 0x3C back-to-back at DIV=3 -> the second start bit begins the cycle after the first stop bit ends (no idle gap).
4. Write DIV=0 and push 0xFF -> every bit lasts exactly 1 clk (10-clk frame).
5. Change DIV from 4 to 8 at DATA bit 3 -> the current frame stays at 4 clk/bit; the next frame runs at 8.
6. Assert rst during DATA bit 5 -> tx=1, STATUS reads empty=1, busy=0, DIV=434 on the next cycle; with SERIAL_PARITY_EN defined and odd selected, 0x01 sends a parity bit of 0.
